bios_program_loader: RTL and testbench

//  Boot-time loader upstream of the BIOS/memory instruction mux. Accepts a word stream
//  (header + payload), writes payload to instruction memory from BASE_ADDR, then emits a

---
 rtl/bios_program_loader_pkg.sv | 26 ++
 rtl/loader_xor_acc.sv | 21 ++
 rtl/bios_program_loader.sv | 166 ++++++++++++++++
 tb/tb_bios_program_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bios_program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encodings,
// the HALT opcode, BIOS/MEMORY fetch-select encodings and default widths.
package bios_program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_COPY   = 3'd2,
        S_CHECK  = 3'd3,
        S_PULSE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } loader_state_e;

    localparam logic [5:0] HALT_OPCODE    = 6'b011101;
    localparam logic       SEL_BIOS       = 1'b0;
    localparam logic       SEL_MEMORY     = 1'b1;
    localparam int         DEF_DATA_WIDTH = 32;
    localparam int         DEF_ADDR_WIDTH = 10;

    // A payload length is usable when it is non-zero and fits above BASE_ADDR.
    function automatic logic header_len_ok(input logic [63:0] n, input logic [63:0] capacity);
        return (n != 64'd0) && (n <= capacity);
    endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// Running XOR accumulator used for the optional payload checksum
// (only instantiated when BIOS_LOADER_CHECKSUM_EN is defined).
module loader_xor_acc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] acc
);

    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ data;
        end
    end

endmodule

// File: rtl/bios_program_loader.sv
// Boot-time loader: header + payload stream into instruction memory, then a core reset
// pulse and load_done. Define BIOS_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module bios_program_loader
    import bios_program_loader_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int BASE_ADDR        = 0,
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic                  core_rst
);

    localparam logic [63:0]    CAPACITY   = (64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR);
    localparam int             PCW        = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [PCW-1:0] PULSE_LAST = PCW'(RST_PULSE_CYCLES - 1);
`ifdef BIOS_LOADER_CHECKSUM_EN
    localparam loader_state_e  AFTER_COPY = S_CHECK;
`else
    localparam loader_state_e  AFTER_COPY = S_PULSE;
`endif

    loader_state_e         state_q, state_d;
    logic                  beat;
    logic                  hdr_beat;
    logic                  copy_beat;
    logic [ADDR_WIDTH:0]   n_words_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [PCW-1:0]        pulse_cnt_q;
    logic                  mem_we_p1;
    logic [ADDR_WIDTH-1:0] mem_addr_p1;
    logic [DATA_WIDTH-1:0] mem_wdata_p1;

`ifdef BIOS_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_sum;

    loader_xor_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xor_acc (
        .clk   (clk),
        .clear (rst | hdr_beat),
        .en    (copy_beat),
        .data  (src_data),
        .acc   (xor_sum)
    );
`endif

    assign beat = src_valid & src_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_ready = 1'b0;
        busy      = 1'b0;
        core_rst  = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        hdr_beat  = 1'b0;
        copy_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HEADER;
            end
            S_HEADER: begin
                src_ready = 1'b1;
                busy      = 1'b1;
                if (beat) begin
                    hdr_beat = 1'b1;
                    state_d  = header_len_ok(64'(src_data), CAPACITY) ? S_COPY : S_ERROR;
                end
            end
            S_COPY: begin
                src_ready = 1'b1;
                busy      = 1'b1;
                if (beat) begin
                    copy_beat = 1'b1;
                    if (count_q == n_words_q - (ADDR_WIDTH+1)'(1)) state_d = AFTER_COPY;
                end
            end
`ifdef BIOS_LOADER_CHECKSUM_EN
            S_CHECK: begin
                src_ready = 1'b1;
                busy      = 1'b1;
                if (beat) state_d = (src_data == xor_sum) ? S_PULSE : S_ERROR;
            end
`endif
            S_PULSE: begin
                busy     = 1'b1;
                core_rst = 1'b1;
                if (pulse_cnt_q == PULSE_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                load_done = 1'b1;
                if (start) state_d = S_HEADER;
            end
            S_ERROR: begin
                load_err = 1'b1;
                if (start) state_d = S_HEADER;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state_q != S_PULSE) begin
            pulse_cnt_q <= '0;
        end else begin
            pulse_cnt_q <= pulse_cnt_q + PCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_words_q <= '0;
            count_q   <= '0;
            addr_q    <= '0;
        end else if (hdr_beat) begin
            n_words_q <= src_data[ADDR_WIDTH:0];
            count_q   <= '0;
            addr_q    <= ADDR_WIDTH'(BASE_ADDR);
        end else if (copy_beat) begin
            count_q   <= count_q + (ADDR_WIDTH+1)'(1);
            addr_q    <= addr_q + ADDR_WIDTH'(1);
        end
    end

    // Write stage: a payload beat becomes a memory write one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_p1    <= 1'b0;
            mem_addr_p1  <= '0;
            mem_wdata_p1 <= '0;
        end else begin
            mem_we_p1 <= copy_beat;
            if (copy_beat) begin
                mem_addr_p1  <= addr_q;
                mem_wdata_p1 <= src_data;
            end
        end
    end

    assign mem_we    = mem_we_p1;
    assign mem_addr  = mem_addr_p1;
    assign mem_wdata = mem_wdata_p1;

endmodule

// File: tb/tb_bios_program_loader.sv
// Directed self-checking bench for bios_program_loader; the checksum scenario is
// exercised only when BIOS_LOADER_CHECKSUM_EN is defined.
module tb_bios_program_loader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int BASE  = 0;
    localparam int PULSE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic          core_rst;

    bios_program_loader #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .BASE_ADDR        (BASE),
        .RST_PULSE_CYCLES (PULSE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err),
        .core_rst  (core_rst)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            rst_cycles = 0;
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            wr_cyc[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] tb_xor;
    int            w0;
    int            r0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (core_rst) rst_cycles <= rst_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        w0 = wr_addr.size();
        r0 = rst_cycles;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        int waited = 0;
        bit ok = 1'b0;
        src_valid = 1'b1;
        src_data  = d;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (src_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        src_valid = 1'b0;
        src_data  = 32'hDEAD_BEEF;
        if (!ok) check("beat_accept", 64'd0, 64'd1);
    endtask

    task automatic hdr(input logic [DW-1:0] n);
        tb_xor = '0;
        exp_d.delete();
        beat(n);
    endtask

    task automatic pay(input logic [DW-1:0] d);
        beat(d);
        tb_xor ^= d;
        exp_d.push_back(d);
    endtask

    task automatic trailer();
`ifdef BIOS_LOADER_CHECKSUM_EN
        beat(tb_xor);
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 100 && !(load_done || load_err); i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int n;
        n = wr_addr.size() - w0;
        check({tag, "_nwr"}, 64'(n), 64'(exp_d.size()));
        for (int i = 0; i < n && i < exp_d.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[w0+i]), 64'(BASE + i));
            check($sformatf("%s_data%0d", tag, i), 64'(wr_data[w0+i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(src_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_core", 64'(core_rst), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk);
        #1;

        // Test 1: three words back to back
        mark();
        do_start();
        @(negedge clk);
        check("t1_ready_hdr", 64'(src_ready), 64'd1);
        check("t1_busy_hdr", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        hdr(3);
        pay(32'hA0A0_0001);
        pay(32'hB0B0_0002);
        pay(32'hC0C0_0003);
        trailer();
        wait_end();
        check_writes("t1");
        if (wr_cyc.size() >= w0 + 3) check("t1_consec", 64'(wr_cyc[w0+2] - wr_cyc[w0]), 64'd2);
        check("t1_pulse_len", 64'(rst_cycles - r0), 64'(PULSE));
        check("t1_done", 64'(load_done), 64'd1);
        check("t1_err", 64'(load_err), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_ready", 64'(src_ready), 64'd0);
        check("t1_core", 64'(core_rst), 64'd0);
        @(posedge clk);
        #1;

        // Test 2: bad headers N=0 and N=capacity+1
        mark();
        do_start();
        hdr(0);
        @(negedge clk);
        check("t2_err0", 64'(load_err), 64'd1);
        check("t2_ready0", 64'(src_ready), 64'd0);
        check("t2_busy0", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        do_start();
        @(negedge clk);
        check("t2_errclr", 64'(load_err), 64'd0);
        @(posedge clk);
        #1;
        hdr(32'd1025);
        repeat (3) @(negedge clk);
        check("t2_err_big", 64'(load_err), 64'd1);
        check("t2_ready_big", 64'(src_ready), 64'd0);
        check("t2_core", 64'(rst_cycles - r0), 64'd0);
        check_writes("t2");
        @(posedge clk);
        #1;

        // Test 2b: full-capacity load is accepted
        mark();
        do_start();
        hdr(32'd1024);
        for (int i = 0; i < 1024; i++) pay(32'h5000_0000 + 32'(i * 3));
        trailer();
        wait_end();
        check("t2b_done", 64'(load_done), 64'd1);
        check_writes("t2b");
        @(posedge clk);
        #1;

        // Test 3: stalled stream
        mark();
        do_start();
        hdr(4);
        for (int i = 0; i < 4; i++) begin
            pay(32'h3300_0010 + 32'(i));
            @(posedge clk);
            #1;
        end
        trailer();
        wait_end();
        check_writes("t3");
        check("t3_done", 64'(load_done), 64'd1);
        @(posedge clk);
        #1;

        // Test 4: reset mid-load
        mark();
        do_start();
        hdr(5);
        pay(32'h4400_0001);
        pay(32'h4400_0002);
        rst = 1'b1;
        src_valid = 1'b1;
        src_data = 32'h4400_0003;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_ready", 64'(src_ready), 64'd0);
        check("t4_we", 64'(mem_we), 64'd0);
        check("t4_addr", 64'(mem_addr), 64'd0);
        check("t4_done", 64'(load_done), 64'd0);
        check("t4_core", 64'(core_rst), 64'd0);
        rst = 1'b0;
        src_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_no_pulse", 64'(rst_cycles - r0), 64'd0);
        check("t4_idle", 64'(busy), 64'd0);
        check_writes("t4");
        @(posedge clk);
        #1;

        // Test 6: start ignored mid-copy, restart from DONE
        mark();
        do_start();
        hdr(2);
        pay(32'h6600_0001);
        start = 1'b1;
        pay(32'h6600_0002);
        start = 1'b0;
        trailer();
        wait_end();
        check("t6_done", 64'(load_done), 64'd1);
        check("t6_pulse", 64'(rst_cycles - r0), 64'(PULSE));
        check_writes("t6a");
        @(posedge clk);
        #1;
        mark();
        do_start();
        @(negedge clk);
        check("t6_doneclr", 64'(load_done), 64'd0);
        check("t6_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        hdr(1);
        pay(32'h6600_00AA);
        trailer();
        wait_end();
        check_writes("t6b");
        check("t6_done2", 64'(load_done), 64'd1);
        @(posedge clk);
        #1;

`ifdef BIOS_LOADER_CHECKSUM_EN
        // Test 5: checksum trailer good and bad
        mark();
        do_start();
        hdr(3);
        pay(32'd1);
        pay(32'd2);
        pay(32'd4);
        beat(32'd7);
        wait_end();
        check("t5_done", 64'(load_done), 64'd1);
        check("t5_pulse", 64'(rst_cycles - r0), 64'(PULSE));
        check_writes("t5a");
        @(posedge clk);
        #1;
        mark();
        do_start();
        hdr(3);
        pay(32'd1);
        pay(32'd2);
        pay(32'd4);
        beat(32'd6);
        wait_end();
        check("t5_err", 64'(load_err), 64'd1);
        check("t5_nodone", 64'(load_done), 64'd0);
        check("t5_no_pulse", 64'(rst_cycles - r0), 64'd0);
        check_writes("t5b");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
